// File: rtl/adp_mem_seq.sv
// -----------------------------------------------------------------------------
// adp_mem_seq
//
// Debug memory access sequencer for the TCK domain of the Acadia Debug Port.
// Converts single-cycle read/write pulses from the TAP into one request/grant
// transaction on the shared SRAM arbitration port. Read data is captured after
// RD_LAT cycles. Busy, done and sticky error status go back to the debug
// datapath. Every output comes straight from a flop.
//
// Optional feature (compile-time macro ADP_MEM_SEQ_TIMEOUT_EN):
//   When defined, a request that waits TIMEOUT cycles without a grant is
//   dropped and the sticky error is set. When undefined, REQ waits for a grant
//   indefinitely. Only reset or leaving debug mode ends the wait.
//
// Parameters:
//   ADDR_W  - memory address width
//   DATA_W  - memory data width
//   RD_LAT  - cycles from the grant cycle to valid mem_rdata (1..7)
//   TIMEOUT - maximum ungranted cycles in REQ (1..255), used only with the macro
//
// Ports:
//   adp_tck_i_buf   in   TCK, all flops rise on its posedge
//   adp_trst_i_buf  in   asynchronous active-high reset
//   adp_debug_mode  in   debug session active; low aborts a transaction
//   dbg_rd_req      in   one-cycle read request pulse
//   dbg_wr_req      in   one-cycle write request pulse
//   dbg_addr        in   address, sampled with the request
//   dbg_wdata       in   write data, sampled with the request
//   dbg_err_clr     in   clears the sticky error (a same-cycle set wins)
//   dbg_rdata       out  captured read data, held until the next read completes
//   dbg_rdata_vld   out  one-cycle pulse when dbg_rdata updates
//   dbg_wr_done     out  one-cycle pulse after a write is granted
//   dbg_busy        out  high whenever the sequencer is not idle
//   dbg_err         out  sticky error (collision, overrun, timeout)
//   mem_req         out  request to the SRAM arbiter
//   mem_gnt         in   grant; the access happens when mem_req and mem_gnt are both high
//   mem_we          out  1 = write, 0 = read
//   mem_addr        out  latched address
//   mem_wdata       out  latched write data
//   mem_rdata       in   read data, valid RD_LAT cycles after the grant cycle
// -----------------------------------------------------------------------------
module adp_mem_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              adp_tck_i_buf,
  input  logic              adp_trst_i_buf,
  input  logic              adp_debug_mode,
  input  logic              dbg_rd_req,
  input  logic              dbg_wr_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_err_clr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rdata_vld,
  output logic              dbg_wr_done,
  output logic              dbg_busy,
  output logic              dbg_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Reject illegal parameter values while the design is being built.
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("adp_mem_seq: RD_LAT must be in 1..7");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("adp_mem_seq: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_vld_q, rdata_vld_d;
  logic                wr_done_q, wr_done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic [2:0]          lat_q, lat_d;
  logic                err_set;
  logic                req_any;
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
  logic [7:0]          to_q, to_d;
`endif

  assign req_any = dbg_rd_req | dbg_wr_req;

  // State and output register bank. Reset is asynchronous, so mem_req and
  // every status output fall as soon as reset rises, even mid-transaction.
  always_ff @(posedge adp_tck_i_buf or posedge adp_trst_i_buf) begin
    if (adp_trst_i_buf) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      wr_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      lat_q       <= '0;
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      wr_done_q   <= wr_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      req_q       <= req_d;
      lat_q       <= lat_d;
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  // Next-state and next-output logic. mem_req and dbg_busy are computed from
  // the next state, so they are registered and still line up with the state.
  // The read latency counter is loaded at the grant. Data is captured when
  // the counter reads 1, which is RD_LAT cycles after the grant edge.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    wr_done_d   = 1'b0;
    lat_d       = lat_q;
    err_set     = 1'b0;
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
    to_d        = to_q;
`endif

    case (state_q)
      IDLE: begin
        if (adp_debug_mode && req_any) begin
          if (dbg_rd_req && dbg_wr_req) begin
            err_set = 1'b1;
          end else begin
            state_d = REQ;
            we_d    = dbg_wr_req;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
            to_d    = 8'd0;
`endif
          end
        end
      end

      // Leaving debug mode takes priority over a grant in the same cycle.
      // With the timeout built in, a grant arriving on the final count still
      // goes ahead.
      REQ: begin
        if (req_any) begin
          err_set = 1'b1;
        end
        if (!adp_debug_mode) begin
          state_d = IDLE;
        end else if (mem_gnt) begin
          if (we_q) begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            lat_d   = 3'(RD_LAT);
            state_d = RDWAIT;
          end
        end
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
        else if (to_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else begin
          to_d = to_q + 8'd1;
        end
`endif
      end

      // A read that is already granted is discarded if debug mode drops.
      RDWAIT: begin
        if (req_any) begin
          err_set = 1'b1;
        end
        if (!adp_debug_mode) begin
          state_d = IDLE;
        end else if (lat_q == 3'd1) begin
          rdata_d     = mem_rdata;
          rdata_vld_d = 1'b1;
          state_d     = IDLE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);

    // A set condition in the same cycle as dbg_err_clr wins.
    if (err_set) begin
      err_d = 1'b1;
    end else if (dbg_err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign dbg_rdata     = rdata_q;
  assign dbg_rdata_vld = rdata_vld_q;
  assign dbg_wr_done   = wr_done_q;
  assign dbg_busy      = busy_q;
  assign dbg_err       = err_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_adp_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_adp_mem_seq
//
// Self-checking bench for adp_mem_seq with RD_LAT=2 and TIMEOUT=15.
// A table of transactions is applied in a loop. Each expected completion is
// pushed to a scoreboard queue and popped by a monitor when the DUT pulses
// dbg_rdata_vld or dbg_wr_done. Hand-written sequences then cover collision,
// error clear, debug-mode gating, abort, timeout and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_adp_mem_seq;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              reset;
  logic              adp_debug_mode;
  logic              dbg_rd_req;
  logic              dbg_wr_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_err_clr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rdata_vld;
  logic              dbg_wr_done;
  logic              dbg_busy;
  logic              dbg_err;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  typedef struct {
    bit          isWrite;
    logic [15:0] addr;
    logic [31:0] data;
    int          gntDelay;
    bit          overrun;
  } vec_t;

  typedef struct {
    bit          isRead;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  vec_t        vecs[6];
  int          checksTotal  = 0;
  int          checksPassed = 0;
  logic [31:0] lastRead     = 32'h0;
  int          reqCycles;

  adp_mem_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .adp_tck_i_buf (clock),
    .adp_trst_i_buf(reset),
    .adp_debug_mode(adp_debug_mode),
    .dbg_rd_req    (dbg_rd_req),
    .dbg_wr_req    (dbg_wr_req),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_err_clr   (dbg_err_clr),
    .dbg_rdata     (dbg_rdata),
    .dbg_rdata_vld (dbg_rdata_vld),
    .dbg_wr_done   (dbg_wr_done),
    .dbg_busy      (dbg_busy),
    .dbg_err       (dbg_err),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Free-running TCK with a 10-unit period.
  always #5 clock = ~clock;

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      checksPassed++;
    end
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the active
  // edge. Each completion pulse pops the oldest expectation. A pulse with
  // nothing pending is an error.
  always @(negedge clock) begin
    exp_t e;
    if (dbg_rdata_vld || dbg_wr_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", {30'd0, dbg_rdata_vld, dbg_wr_done}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulseKind", {30'd0, dbg_rdata_vld, dbg_wr_done}, e.isRead ? 32'd2 : 32'd1);
        if (e.isRead) begin
          checkOutput("readData", dbg_rdata, e.data);
        end
      end
    end
  end

  // Drive one table transaction end to end and act as the arbiter and SRAM.
  // The dbg_* inputs are scrambled after the request cycle, which shows that
  // the DUT holds its own latched copy.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    dbg_rd_req = !v.isWrite;
    dbg_wr_req = v.isWrite;
    dbg_addr   = v.addr;
    dbg_wdata  = v.data;
    e.isRead   = !v.isWrite;
    e.data     = v.data;
    expQ.push_back(e);
    @(negedge clock);
    dbg_rd_req = v.overrun;
    dbg_wr_req = 1'b0;
    dbg_addr   = ~v.addr;
    dbg_wdata  = ~v.data;
    checkOutput("memReqRaised", {31'd0, mem_req}, 32'd1);
    checkOutput("busyInReq", {31'd0, dbg_busy}, 32'd1);
    checkOutput("memWe", {31'd0, mem_we}, {31'd0, v.isWrite});
    checkOutput("memAddr", {16'd0, mem_addr}, {16'd0, v.addr});
    if (v.isWrite) begin
      checkOutput("memWdata", mem_wdata, v.data);
    end
    for (int i = 0; i < v.gntDelay; i++) begin
      @(negedge clock);
      dbg_rd_req = 1'b0;
      checkOutput("memReqHeld", {31'd0, mem_req}, 32'd1);
      checkOutput("memAddrHeld", {16'd0, mem_addr}, {16'd0, v.addr});
    end
    mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt    = 1'b0;
    dbg_rd_req = 1'b0;
    checkOutput("memReqDropped", {31'd0, mem_req}, 32'd0);
    if (!v.isWrite) begin
      for (int k = 1; k <= RD_LAT; k++) begin
        checkOutput("busyInRdwait", {31'd0, dbg_busy}, 32'd1);
        mem_rdata = (k == RD_LAT) ? v.data : ~v.data;
        @(negedge clock);
      end
      mem_rdata = ~v.data;
      lastRead  = v.data;
    end
    checkOutput("busyClearAtDone", {31'd0, dbg_busy}, 32'd0);
    @(negedge clock);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);
    checkOutput("doneIsPulse", {30'd0, dbg_rdata_vld, dbg_wr_done}, 32'd0);
    checkOutput("errAfterVector", {31'd0, dbg_err}, {31'd0, v.overrun});
    if (v.overrun) begin
      dbg_err_clr = 1'b1;
      @(negedge clock);
      dbg_err_clr = 1'b0;
      checkOutput("errCleared", {31'd0, dbg_err}, 32'd0);
    end
  endtask

  // Watchdog so the run always ends, even if the DUT wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, table loop, then multi-cycle corner cases.
  initial begin
    reset          = 1'b1;
    adp_debug_mode = 1'b1;
    dbg_rd_req     = 1'b0;
    dbg_wr_req     = 1'b0;
    dbg_addr       = '0;
    dbg_wdata      = '0;
    dbg_err_clr    = 1'b0;
    mem_gnt        = 1'b0;
    mem_rdata      = '0;

    vecs[0] = '{isWrite: 1'b1, addr: 16'h0040, data: 32'hDEADBEEF, gntDelay: 0, overrun: 1'b0};
    vecs[1] = '{isWrite: 1'b0, addr: 16'h0100, data: 32'h12345678, gntDelay: 3, overrun: 1'b0};
    vecs[2] = '{isWrite: 1'b0, addr: 16'hFFFF, data: 32'h00000000, gntDelay: 0, overrun: 1'b1};
    vecs[3] = '{isWrite: 1'b1, addr: 16'hFFFF, data: 32'hFFFFFFFF, gntDelay: 2, overrun: 1'b1};
    vecs[4] = '{isWrite: 1'b1, addr: 16'h1234, data: 32'h00000001, gntDelay: 5, overrun: 1'b0};
    vecs[5] = '{isWrite: 1'b0, addr: 16'h0000, data: 32'hA5A5A5A5, gntDelay: 1, overrun: 1'b0};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("resetRdata", dbg_rdata, 32'd0);
    checkOutput("resetFlags", {26'd0, dbg_rdata_vld, dbg_wr_done, dbg_busy, dbg_err, mem_req, mem_we}, 32'd0);
    checkOutput("resetAddr", {16'd0, mem_addr}, 32'd0);
    checkOutput("resetWdata", mem_wdata, 32'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
    end

    // Read and write together in IDLE: no transaction, error set.
    dbg_rd_req = 1'b1;
    dbg_wr_req = 1'b1;
    @(negedge clock);
    dbg_rd_req = 1'b0;
    dbg_wr_req = 1'b0;
    checkOutput("collisionNoReq", {30'd0, mem_req, dbg_busy}, 32'd0);
    checkOutput("collisionErr", {31'd0, dbg_err}, 32'd1);
    // Clear and set in the same cycle: the set wins.
    dbg_rd_req  = 1'b1;
    dbg_wr_req  = 1'b1;
    dbg_err_clr = 1'b1;
    @(negedge clock);
    dbg_rd_req = 1'b0;
    dbg_wr_req = 1'b0;
    checkOutput("setBeatsClear", {31'd0, dbg_err}, 32'd1);
    @(negedge clock);
    dbg_err_clr = 1'b0;
    checkOutput("clearAlone", {31'd0, dbg_err}, 32'd0);

    // Requests outside debug mode are ignored and do not set the error.
    adp_debug_mode = 1'b0;
    dbg_rd_req     = 1'b1;
    @(negedge clock);
    dbg_rd_req     = 1'b0;
    adp_debug_mode = 1'b1;
    checkOutput("noDebugIgnored", {30'd0, mem_req, dbg_err}, 32'd0);

    // Abort in RDWAIT: back to IDLE, no valid pulse, error unchanged, data held.
    dbg_rd_req = 1'b1;
    dbg_addr   = 16'h0200;
    @(negedge clock);
    dbg_rd_req = 1'b0;
    mem_gnt    = 1'b1;
    @(negedge clock);
    mem_gnt        = 1'b0;
    adp_debug_mode = 1'b0;
    mem_rdata      = 32'hCAFEF00D;
    @(negedge clock);
    checkOutput("abortIdle", {29'd0, dbg_busy, mem_req, dbg_err}, 32'd0);
    adp_debug_mode = 1'b1;
    repeat (RD_LAT + 1) @(negedge clock);
    checkOutput("abortRdataHeld", dbg_rdata, lastRead);
    checkOutput("abortNoPulse", expQ.size(), 32'd0);

    // Ungranted request: timeout if built in, otherwise waits indefinitely.
    dbg_rd_req = 1'b1;
    dbg_addr   = 16'h0300;
    @(negedge clock);
    dbg_rd_req = 1'b0;
    reqCycles  = 0;
    while (mem_req && reqCycles < 100) begin
      reqCycles++;
      @(negedge clock);
    end
`ifdef ADP_MEM_SEQ_TIMEOUT_EN
    checkOutput("timeoutCycles", reqCycles, TIMEOUT);
    checkOutput("timeoutErr", {30'd0, dbg_err, dbg_busy}, 32'd2);
    dbg_err_clr = 1'b1;
    @(negedge clock);
    dbg_err_clr = 1'b0;
`else
    checkOutput("noTimeoutCycles", reqCycles, 32'd100);
    checkOutput("noTimeoutStillReq", {30'd0, mem_req, dbg_err}, 32'd2);
    adp_debug_mode = 1'b0;
    @(negedge clock);
    adp_debug_mode = 1'b1;
    checkOutput("noTimeoutAbort", {30'd0, mem_req, dbg_busy}, 32'd0);
`endif

    // Asynchronous reset between edges while in REQ, with the error set first.
    dbg_rd_req = 1'b1;
    dbg_wr_req = 1'b1;
    @(negedge clock);
    dbg_rd_req = 1'b0;
    dbg_wr_req = 1'b0;
    dbg_wr_req = 1'b1;
    dbg_addr   = 16'h0BEE;
    dbg_wdata  = 32'h55AA55AA;
    @(negedge clock);
    dbg_wr_req = 1'b0;
    checkOutput("preResetInReq", {29'd0, mem_req, mem_we, dbg_err}, 32'd7);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetFlags", {26'd0, dbg_rdata_vld, dbg_wr_done, dbg_busy, dbg_err, mem_req, mem_we}, 32'd0);
    checkOutput("asyncResetRdata", dbg_rdata, 32'd0);
    checkOutput("asyncResetAddr", {16'd0, mem_addr}, 32'd0);
    checkOutput("asyncResetWdata", mem_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("postResetIdle", {30'd0, mem_req, dbg_busy}, 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
